// File: rtl/bip_tx_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bip_tx_scheduler
//
// Sequences the UART transmitter after the BIP core halts. While the core
// runs, every valid instruction is counted. When HLT (16'h0000) is seen on
// the instruction bus, the core is frozen, {accumulator, count} is latched
// into a frame, and the frame is sent one byte at a time (LSB first), with
// each byte waiting for the UART's done pulse.
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_instruccion  instruction issued by the core
//   i_valid        i_instruccion executes this cycle
//   i_acc          core accumulator
//   i_tx_done      UART finished the current byte (1-cycle pulse)
//   i_restart      leave DONE and start a new run
//   o_cpu_enable   core clock-enable, high only in RUN
//   o_tx_start     1-cycle pulse, UART loads o_tx_data
//   o_tx_data      byte to transmit
//   o_busy         high while a frame is being sent (START or WAIT)
//   o_done         high once the whole frame has been sent
//   o_dbg_state    current FSM state (RUN=0, START=1, WAIT=2, DONE=3)
//
// Handshake: o_tx_start is a single-cycle request with o_tx_data valid in the
// same cycle; o_tx_data then holds until the UART answers with a single-cycle
// i_tx_done, which is only accepted in the cycle after the request or later.
// ---------------------------------------------------------------------------
module bip_tx_scheduler #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [15:0]       i_instruccion,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_acc,
    input  logic              i_tx_done,
    input  logic              i_restart,
    output logic              o_cpu_enable,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_dbg_state
);

    localparam int FRAME_W = CNT_W + DATA_W;
    localparam int NBYTES  = FRAME_W / 8;
    localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [FRAME_W-1:0]   r_frame;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_cpu_enable;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic                 r_busy;
    logic                 r_done;

    logic [CNT_W-1:0]     w_count_inc;
    logic                 w_is_hlt;
    logic [FRAME_W-1:0]   w_frame_shift;
    logic                 w_last_byte;

    // The HLT itself is counted, so the frame carries the incremented count.
    assign w_count_inc   = r_count + CNT_W'(1);
    assign w_is_hlt      = i_valid && (i_instruccion == 16'h0000);
    assign w_frame_shift = r_frame >> 8;
    assign w_last_byte   = (r_idx == LAST_IDX);

    // Outputs are registered alongside the state transition, so each output
    // takes the value belonging to the state being entered.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_frame      <= '0;
            r_idx        <= '0;
            r_cpu_enable <= 1'b1;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (i_valid) begin
                        r_count <= w_count_inc;
                    end
                    if (w_is_hlt) begin
                        r_frame      <= {i_acc, w_count_inc};
                        r_idx        <= '0;
                        r_state      <= ST_START;
                        r_cpu_enable <= 1'b0;
                        r_tx_start   <= 1'b1;
                        r_tx_data    <= w_count_inc[7:0];
                        r_busy       <= 1'b1;
                    end
                end

                // One-cycle request; a done pulse seen here is too early and
                // is deliberately dropped.
                ST_START: begin
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_tx_done) begin
                        r_frame <= w_frame_shift;
                        r_idx   <= r_idx + IDX_W'(1);
                        if (w_last_byte) begin
                            r_state   <= ST_DONE;
                            r_tx_data <= 8'h00;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state    <= ST_START;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_frame_shift[7:0];
                        end
                    end
                end

                ST_DONE: begin
                    if (i_restart) begin
                        r_count      <= '0;
                        r_state      <= ST_RUN;
                        r_cpu_enable <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_cpu_enable = r_cpu_enable;
    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bip_tx_scheduler.sv
`timescale 1ns/1ps
module tb_bip_tx_scheduler;

    logic        i_clock;
    logic        i_reset;
    logic [15:0] i_instruccion;
    logic        i_valid;
    logic [15:0] i_acc;
    logic        i_tx_done;
    logic        i_restart;
    logic        o_cpu_enable;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_dbg_state;

    bip_tx_scheduler #(.DATA_W(16), .CNT_W(16)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_instruccion (i_instruccion),
        .i_valid       (i_valid),
        .i_acc         (i_acc),
        .i_tx_done     (i_tx_done),
        .i_restart     (i_restart),
        .o_cpu_enable  (o_cpu_enable),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #1500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         n_starts = 0;
    logic [7:0] exp_q[$];

    // Count every o_tx_start pulse seen at a falling edge.
    always @(negedge i_clock) begin
        if (o_tx_start) n_starts++;
    end

    typedef struct {
        int              n_instr;
        logic [15:0]     acc;
        logic [3:0][7:0] exp_b;   // exp_b[0] is sent first
        int              gap;
        bit              spur;
        bit              noise;
        string           name;
    } vec_t;

    vec_t vecs[5];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge i_clock);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_start(input string name);
        int t;
        t = 0;
        while (!o_tx_start && t < 50) begin
            tick();
            t++;
        end
        check({name, " start"}, {31'd0, o_tx_start}, 32'd1);
    endtask

    task automatic run_instrs(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            i_valid       = 1'b1;
            i_instruccion = 16'($urandom_range(1, 65535));
            i_tx_done     = spur && i[0];
            tick();
        end
        i_valid   = 1'b0;
        i_tx_done = 1'b0;
    endtask

    task automatic restart_if_done(input string name);
        if (o_done) begin
            i_restart = 1'b1;
            tick();
            i_restart = 1'b0;
            check({name, " restart"}, {29'd0, o_cpu_enable, o_done, o_busy}, 32'b100);
        end
    endtask

    // Issue HLT; returns the start-pulse count captured before the frame.
    task automatic issue_hlt(input logic [15:0] acc, input string name, output int s0);
        s0            = n_starts;
        i_acc         = acc;
        i_instruccion = 16'h0000;
        i_valid       = 1'b1;
        tick();
        i_valid       = 1'b0;
        i_instruccion = 16'h1111;
        check({name, " hlt"}, {29'd0, o_cpu_enable, o_tx_start, o_busy}, 32'b011);
    endtask

    // UART model: answers each start after gap+1 cycles.
    task automatic do_frame(input logic [3:0][7:0] exp_b, input int gap, input bit spur,
                            input bit noise, input int s0, input string name);
        logic [7:0] e;
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_b[b]);
        for (int b = 0; b < 4; b++) begin
            e = exp_q.pop_front();
            wait_start($sformatf("%s b%0d", name, b));
            check($sformatf("%s b%0d data", name, b), {24'd0, o_tx_data}, {24'd0, e});
            check($sformatf("%s b%0d busy", name, b), {31'd0, o_busy}, 32'd1);
            if (spur) i_tx_done = 1'b1;   // lands in START, must be ignored
            tick();
            i_tx_done = 1'b0;
            if (noise) begin
                i_valid       = 1'b1;
                i_instruccion = 16'h0000;
                i_restart     = 1'b1;
            end
            repeat (gap) tick();
            check($sformatf("%s b%0d hold", name, b), {23'd0, o_tx_start, o_tx_data}, {23'd0, 1'b0, e});
            i_valid   = 1'b0;
            i_restart = 1'b0;
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        check({name, " done"}, {20'd0, o_done, o_busy, o_cpu_enable, o_tx_start, o_tx_data},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        check({name, " nstarts"}, 32'(n_starts - s0), 32'd4);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {19'd0, o_cpu_enable, o_tx_start, o_tx_data, o_busy, o_done, o_dbg_state},
              {19'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0});
    endtask

    // ---------------- test ----------------
    initial begin
        int s0;

        vecs[0] = '{5,   16'hBEEF, {8'hBE, 8'hEF, 8'h00, 8'h06}, 9, 1'b0, 1'b0, "basic"};
        vecs[1] = '{0,   16'h0000, {8'h00, 8'h00, 8'h00, 8'h01}, 9, 1'b0, 1'b0, "imm_hlt"};
        vecs[2] = '{3,   16'h1234, {8'h12, 8'h34, 8'h00, 8'h04}, 3, 1'b0, 1'b1, "restart"};
        vecs[3] = '{2,   16'hA5C3, {8'hA5, 8'hC3, 8'h00, 8'h03}, 0, 1'b1, 1'b0, "abuse"};
        vecs[4] = '{299, 16'h7E81, {8'h7E, 8'h81, 8'h01, 8'h2C}, 1, 1'b0, 1'b0, "cnt300"};

        i_reset       = 1'b1;
        i_instruccion = 16'h1111;
        i_valid       = 1'b0;
        i_acc         = 16'h0000;
        i_tx_done     = 1'b0;
        i_restart     = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        i_reset = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            restart_if_done(vecs[v].name);
            run_instrs(vecs[v].n_instr, vecs[v].spur);
            issue_hlt(vecs[v].acc, vecs[v].name, s0);
            do_frame(vecs[v].exp_b, vecs[v].gap, vecs[v].spur, vecs[v].noise, s0, vecs[v].name);
        end

        // Counter wrap: 65535 + HLT = 65536 -> count 0.
        restart_if_done("wrap");
        run_instrs(65535, 1'b0);
        issue_hlt(16'hC0DE, "wrap", s0);
        do_frame({8'hC0, 8'hDE, 8'h00, 8'h00}, 2, 1'b0, 1'b0, s0, "wrap");

        // Asynchronous reset while waiting on byte 1.
        restart_if_done("midrst");
        run_instrs(2, 1'b0);
        issue_hlt(16'hABCD, "midrst", s0);
        check("midrst b0", {24'd0, o_tx_data}, 32'h03);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("midrst b1 start", {23'd0, o_tx_start, o_tx_data}, {23'd0, 1'b1, 8'h00});
        tick();
        #2 i_reset = 1'b1;
        #1 check_reset_outputs("midrst async");
        tick();
        check_reset_outputs("midrst held");
        i_reset = 1'b0;
        tick();
        issue_hlt(16'h0055, "postrst", s0);
        do_frame({8'h00, 8'h55, 8'h00, 8'h01}, 4, 1'b0, 1'b0, s0, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bip_tx_scheduler.md
# bip_tx_scheduler

Sequences the UART transmitter after the BIP processor halts. While the processor runs, the block counts executed instructions. When it detects HLT (16'h0000) on the instruction bus, it freezes the processor, latches the accumulator and the instruction count into a frame, and sends the frame byte by byte to the UART TX, waiting for the TX handshake on each byte. It sits between the BIP core and the UART transmitter and replaces the combinational HLT-to-tx_start path.

## Interface
Parameters:
- DATA_W, 16: accumulator width; multiple of 8.
- CNT_W, 16: instruction counter width; multiple of 8.

Ports:
- i_clock, in, 1: single system clock; all state updates on its rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_instruccion, in, 16: instruction currently issued by the core.
- i_valid, in, 1: i_instruccion is valid and executes this cycle.
- i_acc, in, DATA_W: core accumulator value.
- i_tx_done, in, 1: UART TX finished the current byte (1-cycle pulse).
- i_restart, in, 1: leaves DONE and starts a new run.
- o_cpu_enable, out, 1: core clock-enable; high only in RUN.
- o_tx_start, out, 1: 1-cycle pulse; UART loads o_tx_data.
- o_tx_data, out, 8: byte to transmit.
- o_busy, out, 1: high in START or WAIT.
- o_done, out, 1: high in DONE.

## Operation
- Frame: {i_acc, count}, shifted out LSB first. Bytes 0..CNT_W/8-1 carry the count (LSB first), then DATA_W/8 accumulator bytes (LSB first). NBYTES = (CNT_W+DATA_W)/8, which is 4 by default.
- Counter: CNT_W bits. It increments on every i_valid cycle in RUN, HLT included, and wraps modulo 2^CNT_W (no saturation). It is latched into the frame on HLT.
- FSM states: RUN, START, WAIT, DONE.
  - RUN: when i_valid and i_instruccion == 16'h0000, load frame = {i_acc, count+1}, clear the byte index, go to START. All other cycles stay in RUN.
  - START: o_tx_start = 1 and o_tx_data = frame[7:0]. Always goes to WAIT next cycle.
  - WAIT: hold o_tx_data. On i_tx_done, shift the frame right by 8 and increment the byte index. If the completed byte was byte NBYTES-1, go to DONE; otherwise go to START.
  - DONE: all outputs idle except o_done. On i_restart, clear the counter and go to RUN.
- Inputs ignored by state:
  - i_tx_done outside WAIT.
  - i_restart outside DONE.
  - i_valid and i_instruccion outside RUN.
- Reset (any time, including mid-frame) returns immediately to:
  - state RUN, counter 0, frame 0, byte index 0;
  - o_cpu_enable = 1, o_tx_start = 0, o_tx_data = 8'h00, o_busy = 0, o_done = 0.
  - A byte in flight in the UART is abandoned; the block does not resend it.

## Timing
- All outputs are decoded from registered state and the frame, so there are no combinational input-to-output paths.
- HLT sampled at edge N:
  - START is active during cycle N..N+1; o_tx_start is high for exactly that one cycle.
  - o_cpu_enable falls in that same cycle. The core must not issue another valid instruction after HLT; if it does, the instruction is ignored.
- i_tx_done sampled at edge M in WAIT: the next START (next byte) is active during cycle M..M+1. Minimum byte-to-byte spacing is 2 cycles plus the UART time.
- i_tx_done arriving the same cycle o_tx_start is high (START) is ignored. The UART must pulse done no earlier than the cycle after start.
- Last byte's i_tx_done at edge M: o_done is high from edge M onward.
- i_restart sampled at edge R in DONE: RUN resumes and o_cpu_enable = 1 after edge R. An instruction valid in the first RUN cycle counts as 1.
- o_tx_data is stable from START through the end of WAIT for each byte.

## Test plan
- Reset mid-frame: assert i_reset while in WAIT on byte 1 -> all outputs return to their reset values asynchronously; a later HLT starts again at byte 0 with count 1.
- Basic frame: 5 valid non-HLT instructions, then HLT with i_acc = 16'hBEEF; UART model returns done 10 cycles after each start -> bytes 06, 00, EF, BE; o_done high after the 4th done; exactly 4 tx_start pulses.
- Immediate HLT: first valid instruction is HLT, i_acc = 16'h0000 -> bytes 01, 00, 00, 00; o_cpu_enable low one cycle after HLT is sampled.
- Wrap: 65535 non-HLT instructions, then HLT -> count wraps to 0; bytes 00, 00, then the accumulator bytes.
- Handshake abuse: i_tx_done pulsed during START and during RUN, plus gaps of 0 cycles between bytes -> spurious pulses do not advance the byte index; no byte is skipped or repeated; no instruction is counted outside RUN.
- Restart: i_restart in DONE, then 3 instructions and HLT with i_acc = 16'h1234 -> bytes 04, 00, 34, 12; i_restart pulsed during WAIT has no effect.
